// File: rtl/shift_round_saturate.sv
// shift_round_saturate
//   Two-stage requantizer that sits directly after the arithmetic shifter.
//   Stage 1 drops FRAC_BITS LSBs with round-half-up. Stage 2 saturates the
//   result to a signed DATA_WIDTH_OUT word. Both sides use a valid/ready
//   handshake, and the two sides may stall independently.
//
//   Optional feature: define SHIFT_SAT_COUNT_EN to add the sat_count port.
//   sat_count is a 16-bit count of saturating output transfers. It sticks at
//   16'hFFFF instead of wrapping.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_data    in   signed shifter result [DATA_WIDTH_IN]
//   in_valid   in   in_data valid
//   in_ready   out  block accepts in_data this cycle
//   out_data   out  rounded, saturated result (registered) [DATA_WIDTH_OUT]
//   out_sat    out  out_data was clipped (registered)
//   out_valid  out  out_data/out_sat valid
//   out_ready  in   downstream accepts this cycle
//   sat_count  out  saturation event count (SHIFT_SAT_COUNT_EN only)
module shift_round_saturate #(
    parameter int unsigned DATA_WIDTH_IN  = 24,
    parameter int unsigned FRAC_BITS      = 4,
    parameter int unsigned DATA_WIDTH_OUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH_IN-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH_OUT-1:0] out_data,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SHIFT_SAT_COUNT_EN
    ,
    output logic [15:0]               sat_count
`endif
);

    localparam int unsigned S1W    = DATA_WIDTH_IN + 1 - FRAC_BITS;
    localparam int unsigned HIW    = S1W - DATA_WIDTH_OUT + 1;
    localparam int unsigned RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic [DATA_WIDTH_IN:0] RND =
        (FRAC_BITS > 0) ? ((DATA_WIDTH_IN + 1)'(1) << RND_SH) : '0;
    localparam logic [DATA_WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH_OUT - 1){1'b1}}};
    localparam logic [DATA_WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH_OUT - 1){1'b0}}};

    // Stage 1 registers
    logic [S1W-1:0]            r_s1_data;
    logic                      r_s1_valid;
    // Stage 2 registers
    logic [DATA_WIDTH_OUT-1:0] r_out_data;
    logic                      r_out_sat;
    logic                      r_out_valid;

    logic                      w_s2_adv;
    logic                      w_in_fire;
    logic [DATA_WIDTH_IN:0]    w_sum;
    logic [S1W-1:0]            w_s1_next;
    logic [HIW-1:0]            w_hi;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;
    logic [DATA_WIDTH_OUT-1:0] w_sat_data;
    logic                      w_sat_flag;

    // Handshake
    assign w_s2_adv  = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_fire = in_valid && in_ready;

    // Round: sign-extend by one bit so adding the half-LSB never wraps. Taking the
    // top bits of the sum is the same as an arithmetic right shift by FRAC_BITS.
    assign w_sum     = {in_data[DATA_WIDTH_IN-1], in_data} + RND;
    assign w_s1_next = w_sum[DATA_WIDTH_IN:FRAC_BITS];

    if (FRAC_BITS > 0) begin : g_frac_unused
        logic w_unused_frac;
        assign w_unused_frac = ^w_sum[FRAC_BITS-1:0];
    end

    // Saturate: the value fits when every bit from the output sign bit upward
    // agrees. A positive sign with any upper one set is overflow; a negative
    // sign with any upper zero set is underflow.
    assign w_hi      = r_s1_data[S1W-1:DATA_WIDTH_OUT-1];
    assign w_pos_ovf = !w_hi[HIW-1] && (|w_hi);
    assign w_neg_ovf = w_hi[HIW-1] && !(&w_hi);

    always_comb begin
        w_sat_data = r_s1_data[DATA_WIDTH_OUT-1:0];
        w_sat_flag = 1'b0;
        if (w_pos_ovf) begin
            w_sat_data = OUT_MAX;
            w_sat_flag = 1'b1;
        end else if (w_neg_ovf) begin
            w_sat_data = OUT_MIN;
            w_sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_data  <= w_s1_next;
                r_s1_valid <= 1'b1;
            end else if (w_s2_adv) begin
                // Stage 1 content has moved into stage 2, or stage 1 was already empty.
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_sat_data;
                r_out_sat  <= w_sat_flag;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;

`ifdef SHIFT_SAT_COUNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (r_out_valid && out_ready && r_out_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_shift_round_saturate.sv
module tb_shift_round_saturate;

    logic        clk;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
`ifdef SHIFT_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_recv   = 0;
    logic [8:0] exp_q[$];  // {sat, data} of accepted words, in order

    shift_round_saturate #(
        .DATA_WIDTH_IN (24),
        .FRAC_BITS     (4),
        .DATA_WIDTH_OUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SHIFT_SAT_COUNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: floor((x + 8) / 16), then clip to [-128, 127].
    function automatic logic [8:0] model(input logic [23:0] x);
        longint v;
        longint q;
        logic [63:0] qb;
        v = longint'($signed(x)) + 8;
        q = v / 16;
        if (v < 0 && (v % 16) != 0) q = q - 1;
        if (q > 127) return {1'b1, 8'h7F};
        if (q < -128) return {1'b1, 8'h80};
        qb = q;
        return {1'b0, qb[7:0]};
    endfunction

    // One cycle. Called just after a negedge: drive the inputs, settle, account
    // for transfers at the coming posedge, then advance to the next negedge.
    task automatic step(input logic v, input logic [23:0] d, input logic ordy,
                        output logic acc);
        logic [8:0] e;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {23'd0, out_sat, out_data}, 32'h1FF);
            end else begin
                e = exp_q.pop_front();
                check("stream_word", {23'd0, out_sat, out_data}, {23'd0, e});
                n_recv++;
            end
        end
        if (acc) exp_q.push_back(model(d));
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            step(1'b0, 24'd0, 1'b1, acc);
            guard++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic [23:0] dir_in  [5];
        logic [8:0]  dir_exp [5];
        logic        acc;
        logic [23:0] d;
        int          sent;
        int          cyc;
        int          exp_sat;

        dir_in[0] = 24'h000038; dir_exp[0] = {1'b0, 8'h04};
        dir_in[1] = 24'hFFFFD8; dir_exp[1] = {1'b0, 8'hFE};
        dir_in[2] = 24'h0007F7; dir_exp[2] = {1'b0, 8'h7F};
        dir_in[3] = 24'h0007F8; dir_exp[3] = {1'b1, 8'h7F};
        dir_in[4] = 24'hFFF000; dir_exp[4] = {1'b1, 8'h80};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed rounding / saturation with two-cycle latency
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = dir_in[i];
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("latency_not_early", out_valid, 0);
            @(negedge clk);
            #1;
            check("latency_valid", out_valid, 1);
            check("directed_word", {23'd0, out_sat, out_data}, {23'd0, dir_exp[i]});
            @(negedge clk);
        end

        // Backpressure: two words fill the pipe, the third is refused
        step(1'b1, 24'd16, 1'b0, acc);
        check("bp_accept1", acc, 1);
        step(1'b1, 24'd32, 1'b0, acc);
        check("bp_accept2", acc, 1);
        step(1'b1, 24'd48, 1'b0, acc);
        check("bp_refuse3", acc, 0);
        check("bp_hold_data", out_data, 8'h01);
        check("bp_hold_valid", out_valid, 1);
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 20) begin
            step(1'b1, 24'd48, 1'b1, acc);
            cyc++;
        end
        check("bp_accept3", acc, 1);
        drain("bp_drain");
        check("bp_recv", n_recv, 3);

        // Random valid/ready, 1000 words against the model
        n_recv = 0;
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            if ($urandom_range(0, 3) == 0) d = 24'($urandom);
            else d = 24'($urandom_range(0, 6000) - 3000);
            step(1'($urandom), d, 1'($urandom), acc);
            if (acc) sent++;
            cyc++;
        end
        check("rand_sent", sent, 1000);
        drain("rand_drain");
        check("rand_recv", n_recv, 1000);

        // Reset while both stages are full and stalled
        step(1'b1, 24'd16, 1'b0, acc);
        step(1'b1, 24'd32, 1'b0, acc);
        #1;
        check("rst_full_valid", out_valid, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) step(1'b0, 24'd0, 1'b1, acc);
        check("rst_no_ghost", exp_q.size(), 0);

`ifdef SHIFT_SAT_COUNT_EN
        check("cnt_reset", sat_count, 0);
        step(1'b1, 24'h7FFFFF, 1'b1, acc);
        step(1'b1, 24'h800000, 1'b1, acc);
        step(1'b1, 24'h0007F8, 1'b1, acc);
        step(1'b1, 24'h000010, 1'b1, acc);
        step(1'b1, 24'h000000, 1'b1, acc);
        drain("cnt_drain");
        #1;
        check("cnt_three", sat_count, 3);
        exp_sat = 3;
        for (int i = 0; i < 65537; i++) begin
            step(1'b1, 24'h100000, 1'b1, acc);
            if (acc) exp_sat++;
        end
        drain("cnt_sat_drain");
        #1;
        check("cnt_enough_sent", (exp_sat > 65535) ? 1 : 0, 1);
        check("cnt_sticky", sat_count, 16'hFFFF);
`else
        exp_sat = 0;
        check("cnt_absent_sat_unused", exp_sat, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
